// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-style core: FETCH/DECODE/EXEC/MEM/WB sequencing over
// external instruction and data memories with req/ack handshakes.
module mc_cpu_core #(
    parameter int unsigned    IAW      = 8,
    parameter int unsigned    DAW      = 8,
    parameter logic [IAW-1:0] START_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [IAW-1:0]   imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DAW-1:0]   dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_ack,
    output logic             halted,
    output logic             retire,
    output logic             illegal,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic [IAW-1:0]   pc_dbg
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RAW  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    state_t state_q, state_d;

    logic [IAW-1:0]  pc_q;
    logic [XLEN-1:0] ir_q, a_q, b_q, aluout_q, mdr_q;
    logic [XLEN-1:0] rf [NREG];
    logic            zero_q, carry_q, retire_q, illegal_q, halted_q;
    logic            retire_d, illegal_d;

    logic [5:0]      op, funct;
    logic [RAW-1:0]  rs, rt, rd, shamt;
    logic [XLEN-1:0] simm;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];
    assign simm  = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

    // ALU and instruction legality, evaluated from IR, A and B during EXEC
    logic [XLEN:0]   sum_rr, sum_ri;
    logic [XLEN-1:0] alu_res;
    logic            alu_c, set_z, set_c, legal;

    assign sum_rr = {1'b0, a_q} + {1'b0, b_q};
    assign sum_ri = {1'b0, a_q} + {1'b0, simm};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        set_z   = 1'b0;
        set_c   = 1'b0;
        legal   = 1'b1;
        case (op)
            OP_RTYPE: begin
                set_z = 1'b1;
                case (funct)
                    FN_ADD: begin
                        alu_res = sum_rr[XLEN-1:0];
                        alu_c   = sum_rr[XLEN];
                        set_c   = 1'b1;
                    end
                    FN_SUB: begin
                        alu_res = a_q - b_q;
                        alu_c   = (a_q >= b_q);
                        set_c   = 1'b1;
                    end
                    FN_AND: alu_res = a_q & b_q;
                    FN_OR:  alu_res = a_q | b_q;
                    FN_SLT: alu_res = XLEN'($signed(a_q) < $signed(b_q));
                    FN_SLL: alu_res = b_q << shamt;
                    default: begin
                        legal = 1'b0;
                        set_z = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_res = sum_ri[XLEN-1:0];
                alu_c   = sum_ri[XLEN];
                set_z   = 1'b1;
                set_c   = 1'b1;
            end
            OP_LW, OP_SW: alu_res = sum_ri[XLEN-1:0];
            OP_BEQ, OP_BNE, OP_J, OP_HALT: ;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (!legal) begin
                    illegal_d = 1'b1;
                    retire_d  = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    case (op)
                        OP_BEQ, OP_BNE, OP_J: begin
                            retire_d = 1'b1;
                            state_d  = ST_FETCH;
                        end
                        OP_LW, OP_SW: state_d = ST_MEM;
                        OP_HALT: begin
                            retire_d = 1'b1;
                            state_d  = ST_HALT;
                        end
                        default: state_d = ST_WB;
                    endcase
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_SW) begin
                        retire_d = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                retire_d = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath registers and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= START_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            halted_q  <= (state_d == ST_HALT);
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_q <= imem_rdata;
                        pc_q <= pc_q + IAW'(1);
                    end
                end
                ST_DECODE: begin
                    a_q <= (rs == '0) ? '0 : rf[rs];
                    b_q <= (rt == '0) ? '0 : rf[rt];
                end
                ST_EXEC: begin
                    aluout_q <= alu_res;
                    if (set_z) zero_q  <= (alu_res == '0);
                    if (set_c) carry_q <= alu_c;
                    if ((op == OP_BEQ && a_q == b_q) || (op == OP_BNE && a_q != b_q))
                        pc_q <= pc_q + IAW'(simm);
                    else if (op == OP_J)
                        pc_q <= ir_q[IAW-1:0];
                end
                ST_MEM: begin
                    if (dmem_ack && op != OP_SW) mdr_q <= dmem_rdata;
                end
                ST_WB: begin
                    if (op == OP_RTYPE) begin
                        if (rd != '0) rf[rd] <= aluout_q;
                    end else if (rt != '0) begin
                        rf[rt] <= (op == OP_LW) ? mdr_q : aluout_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests follow the state directly so reset withdraws them at once
    assign imem_req   = rst_n & (state_q == ST_FETCH);
    assign dmem_req   = rst_n & (state_q == ST_MEM);
    assign imem_addr  = pc_q;
    assign dmem_addr  = aluout_q[DAW-1:0];
    assign dmem_we    = (op == OP_SW);
    assign dmem_wdata = b_q;
    assign halted     = halted_q;
    assign retire     = retire_q;
    assign illegal    = illegal_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign pc_dbg     = pc_q;

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
Parameterised multi-cycle successor to the single-cycle CPU. It executes a MIPS-style 32-bit subset through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories sit outside the core behind req/ack handshakes, so they may insert wait states. Internal blocks are a 32x32 register file with r0 hardwired to 0, zero and carry flags, and a HALT mechanism.

Parameters:
IAW, 8, instruction word-address width (PC width)
DAW, 8, data word-address width; the ALU result is truncated to DAW bits for dmem_addr
START_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  instruction fetch request
imem_addr  out  IAW  fetch word address (current PC)
imem_rdata  in  32  instruction word
imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  DAW  data word address
dmem_wdata  out  32  store data (rt value)
dmem_rdata  in  32  load data
dmem_ack  in  1  data access complete
halted  out  1  core is in HALT
retire  out  1  1-cycle pulse when an instruction completes
illegal  out  1  1-cycle pulse on an unknown opcode or funct
zero_flag  out  1  registered zero flag
carry_flag  out  1  registered carry flag
pc_dbg  out  IAW  current PC

Behaviour:
- Reset (async) sets:
  - state=FETCH, PC=START_PC, all registers 0, flags 0, IR=0.
  - All req, pulse and halted outputs 0.
  - Reqs are decoded from state and the stall condition, so they drop immediately on reset. Any in-flight memory transaction is abandoned.
- Handshake:
  - req rises on entry to FETCH or MEM.
  - Address, we and wdata are held stable while req=1.
  - Completion is the first posedge with req=1 and ack=1. Data is captured at that edge and req falls the next cycle.
  - Zero-wait operation (ack in the first req cycle) is legal.
  - ack while req=0 is ignored.
- Decode: op=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], shamt=IR[10:6], funct=IR[5:0], imm=IR[15:0] sign-extended to 32 bits.
- ISA:
  - R-type (op 0x00), result written to rd:
    - ADD 0x20: carry = bit 32 of the unsigned sum.
    - SUB 0x22: carry = no-borrow (rs>=rt unsigned).
    - AND 0x24, OR 0x25, SLT 0x2A (signed): carry unchanged.
    - SLL 0x00: rt<<shamt.
  - ADDI 0x08: rt = rs+simm; carry as for ADD.
  - LW 0x23: rt = mem[rs+simm]. SW 0x2B: mem[rs+simm] = rt.
  - BEQ 0x04 / BNE 0x05: PC = PC+1+simm, truncated to IAW, mod 2^IAW.
  - J 0x02: PC = IR[IAW-1:0].
  - HALT 0x3F.
- Flags:
  - zero_flag updates on every R-type and ADDI: 1 when the 32-bit result is 0.
  - carry_flag updates only as listed above.
  - Loads, stores and branches leave both flags unchanged.
- States:
  - FETCH: on ack, IR<=imem_rdata, PC<=PC+1 (wraps), go to DECODE.
  - DECODE: latch A=reg[rs], B=reg[rt], go to EXEC.
  - EXEC:
    - ALU operation, result into register ALUOUT.
    - Branch or J: update PC, retire, go to FETCH. Branch compare uses A and B.
    - LW/SW: go to MEM.
    - R-type/ADDI: go to WB.
    - HALT: go to HALT, retire.
    - Unknown op/funct: pulse illegal, no state change, retire, go to FETCH.
  - MEM: req with address ALUOUT[DAW-1:0]. On ack, SW retires and goes to FETCH; LW latches MDR and goes to WB.
  - WB: write the destination (rd for R-type, rt for ADDI/LW), retire, go to FETCH.
  - HALT: terminal state. halted=1 and no requests are issued; only reset exits.
- Register file: writes to r0 are discarded and reads of r0 return 0. Reads occur in DECODE, so a write in WB is visible to the next instruction.
- Latency with zero-wait memory: ALU ops and LW take 4 and 5 cycles, SW and branch/J take 4 and 3 cycles. Each wait cycle adds one cycle.

Test Plan:
- Zero-wait program `ADDI r1,r0,5; ADDI r2,r0,-5; ADD r3,r1,r2; HALT` -> r3=0, zero_flag=1, carry_flag=1, halted=1. retire pulses at cycles 4, 8, 12 and 15 after reset release.
- `SW r1,4(r0)` with r1=0x1234, then `LW r4,4(r0)`, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with addr=4, we=1 then 0; r4=0x1234; LW total 8 cycles.
- `BEQ r0,r0,-1` at PC=0x10 -> PC returns to 0x10 and the loop repeats every 3 cycles. `BNE r0,r0,-1` -> falls through to 0x11. `J 0x3` from 0xFF -> PC=0x03.
- PC=0xFF with zero-wait fetch -> next imem_addr=0x00. Opcode 0x3E -> illegal pulse for 1 cycle, registers unchanged, fetch continues.
- `ADDI r0,r0,7` then `ADD r5,r0,r0` -> r5=0 and zero_flag=1. `SUB` with 3-5 -> result 0xFFFFFFFE, carry_flag=0.
- rst_n low during a stalled MEM state with dmem_ack=0 -> dmem_req drops asynchronously. After release, state=FETCH, PC=START_PC and imem_req=1.
